mips_multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU's 4-bit aluop and operand selects in every state. It also drives register-file, PC, IR and memory strobes, and handshakes with a memory that may stall. It sits between the instruction register (op/func fields) and the datapath muxes.

---
 rtl/mips_ctrl_pkg.sv | 89 ++++++++
 rtl/alu_op_decode.sv | 40 ++++
 rtl/mips_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencing controller.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_RWB,
        S_EXEC_I,
        S_IWB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_LWB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    // ALU operation encodings
    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_PC      = 2'd0;
    localparam logic [1:0] SRC_A_RS      = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT   = 2'd2;
    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_BRANCH  = 2'd3;
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    function automatic logic func_legal(input logic [5:0] func);
        case (func)
            FN_SLL, FN_SRA, FN_SRL, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB,
            FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Constant-shift forms take the shift amount from the shamt field.
    function automatic logic func_shamt(input logic [5:0] func);
        return (func == FN_SLL) || (func == FN_SRA) || (func == FN_SRL);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps R-type func or I-type op onto the shared ALU operation code.
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       is_rtype,
    output logic [3:0] aluop
);

    // Func decode for R-type, op decode for immediate arithmetic; ADD otherwise.
    always_comb begin
        aluop = ALU_ADD;
        if (is_rtype) begin
            case (func)
                FN_SLL:          aluop = ALU_SLL;
                FN_SRA, FN_SRAV: aluop = ALU_SRA;
                FN_SRL:          aluop = ALU_SRL;
                FN_ADD, FN_ADDU: aluop = ALU_ADD;
                FN_SUB:          aluop = ALU_SUB;
                FN_AND:          aluop = ALU_AND;
                FN_OR:           aluop = ALU_OR;
                FN_NOR:          aluop = ALU_NOR;
                FN_SLT:          aluop = ALU_SLT;
                FN_SLTU:         aluop = ALU_SLTU;
                default:         aluop = ALU_ADD;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_ADDIU: aluop = ALU_ADD;
                OP_SLTI:           aluop = ALU_SLT;
                OP_ANDI:           aluop = ALU_AND;
                OP_ORI:            aluop = ALU_OR;
                OP_XORI:           aluop = ALU_XOR;
                default:           aluop = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: FSM, reset wait counter, output decode.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  S_RESET    | idle RESET_PC_WAIT cycles after reset release
//  S_FETCH    | read instruction at PC, PC+4 on mem_ready
//  S_DECODE   | branch target into ALUOut, dispatch on op/func
//  S_EXEC_R   | R-type ALU operation
//  S_RWB      | write ALUOut to rd
//  S_EXEC_I   | immediate ALU operation
//  S_IWB      | write ALUOut to rt
//  S_MEM_ADDR | effective address rs + sign-extended imm
//  S_MEM_RD   | load data read, hold until mem_ready
//  S_LWB      | write memory data register to rt
//  S_MEM_WR   | store word/byte, hold until mem_ready
//  S_BRANCH   | compare rs/rt, conditional PC load from ALUOut
//  S_JUMP     | PC load from jump target
//  S_TRAP     | undecodable instruction, parked until reset
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int RESET_PC_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_byte,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [3:0] aluop,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [3:0] WAIT_TC = 4'(RESET_PC_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt, wait_d;
    logic [3:0] dec_aluop;

    alu_op_decode u_alu_op_decode (
        .op       (op),
        .func     (func),
        .is_rtype (op == OP_RTYPE),
        .aluop    (dec_aluop)
    );

    // State, reset wait counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (state_d == S_TRAP) begin
                illegal_op <= 1'b1;
            end
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_cnt;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_byte   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RT;
        imm_zext   = 1'b0;
        aluop      = ALU_ADD;
        instr_done = 1'b0;

        case (state_q)
            S_RESET: begin
                if (wait_cnt == WAIT_TC) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_cnt + 4'd1;
                end
            end
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_BRANCH;
                case (op)
                    OP_RTYPE:                 state_d = func_legal(func) ? S_EXEC_R : S_TRAP;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW, OP_SB:      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLEZ:  state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = func_shamt(func) ? SRC_A_SHAMT : SRC_A_RS;
                alu_src_b = SRC_B_RT;
                aluop     = dec_aluop;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                imm_zext  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
                aluop     = dec_aluop;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    state_d = S_LWB;
                end
            end
            S_LWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord     = 1'b1;
                mem_wr   = 1'b1;
                mem_byte = (op == OP_SB);
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS;
                alu_src_b  = SRC_B_RT;
                aluop      = ALU_SUB;
                pc_src     = PC_SRC_ALUOUT;
                instr_done = 1'b1;
                case (op)
                    OP_BEQ:  pc_write = alu_zero;
                    OP_BNE:  pc_write = !alu_zero;
                    OP_BLEZ: pc_write = alu_zero | alu_sign;
                    default: pc_write = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle check of the multi-cycle controller outputs against expected
// per-state output records pushed into a scoreboard queue.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_byte;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       imm_zext;
        logic [3:0] aluop;
        logic       instr_done;
        logic       illegal_op;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        logic       zero;
        logic       sign;
        logic       rdy;
        out_t       exp;
    } row_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       alu_zero;
    logic       alu_sign;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_byte;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] aluop;
    logic       instr_done;
    logic       illegal_op;

    out_t act;
    row_t rows[$];
    sb_t  sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    mips_multicycle_ctrl #(.RESET_PC_WAIT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func       (func),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_byte   (mem_byte),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_zext   (imm_zext),
        .aluop      (aluop),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    assign act = {pc_write, pc_src, ir_write, iord, mem_rd, mem_wr, mem_byte,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  imm_zext, aluop, instr_done, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output records, one per controller state.
    function automatic out_t e_idle();
        out_t o = '0;
        o.aluop = 4'd5;
        return o;
    endfunction
    function automatic out_t e_fetch(input logic rdy);
        out_t o = e_idle();
        o.mem_rd = 1'b1; o.src_b = 2'd1; o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic out_t e_dec();
        out_t o = e_idle();
        o.src_b = 2'd3;
        return o;
    endfunction
    function automatic out_t e_exr(input logic [1:0] a, input logic [3:0] alu);
        out_t o = e_idle();
        o.src_a = a; o.src_b = 2'd0; o.aluop = alu;
        return o;
    endfunction
    function automatic out_t e_rwb();
        out_t o = e_idle();
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_exi(input logic z, input logic [3:0] alu);
        out_t o = e_idle();
        o.src_a = 2'd1; o.src_b = 2'd2; o.imm_zext = z; o.aluop = alu;
        return o;
    endfunction
    function automatic out_t e_iwb();
        out_t o = e_idle();
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_addr();
        out_t o = e_idle();
        o.src_a = 2'd1; o.src_b = 2'd2;
        return o;
    endfunction
    function automatic out_t e_mrd();
        out_t o = e_idle();
        o.iord = 1'b1; o.mem_rd = 1'b1;
        return o;
    endfunction
    function automatic out_t e_lwb();
        out_t o = e_idle();
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mwr(input logic b, input logic rdy);
        out_t o = e_idle();
        o.iord = 1'b1; o.mem_wr = 1'b1; o.mem_byte = b; o.instr_done = rdy;
        return o;
    endfunction
    function automatic out_t e_br(input logic pcw);
        out_t o = e_idle();
        o.src_a = 2'd1; o.aluop = 4'd6; o.pc_src = 2'd1; o.instr_done = 1'b1;
        o.pc_write = pcw;
        return o;
    endfunction
    function automatic out_t e_jmp();
        out_t o = e_idle();
        o.pc_write = 1'b1; o.pc_src = 2'd2; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_trap();
        out_t o = e_idle();
        o.illegal_op = 1'b1;
        return o;
    endfunction

    task automatic add(input string n, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic s, input logic r, input out_t e);
        row_t rw;
        rw.name = n; rw.op = o; rw.func = f; rw.zero = z; rw.sign = s; rw.rdy = r; rw.exp = e;
        rows.push_back(rw);
    endtask

    task automatic add_r(input string n, input logic [5:0] f, input logic [1:0] a, input logic [3:0] alu);
        add({n, "_fetch"}, 6'h00, f, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add({n, "_dec"},   6'h00, f, 1'b0, 1'b0, 1'b1, e_dec());
        add({n, "_exec"},  6'h00, f, 1'b0, 1'b0, 1'b1, e_exr(a, alu));
        add({n, "_wb"},    6'h00, f, 1'b0, 1'b0, 1'b1, e_rwb());
    endtask

    task automatic add_i(input string n, input logic [5:0] o, input logic z, input logic [3:0] alu);
        add({n, "_fetch"}, o, 6'h15, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add({n, "_dec"},   o, 6'h15, 1'b0, 1'b0, 1'b1, e_dec());
        add({n, "_exec"},  o, 6'h15, 1'b0, 1'b0, 1'b1, e_exi(z, alu));
        add({n, "_wb"},    o, 6'h15, 1'b0, 1'b0, 1'b1, e_iwb());
    endtask

    task automatic add_br(input string n, input logic [5:0] o, input logic z, input logic s, input logic pcw);
        add({n, "_fetch"}, o, 6'h00, z, s, 1'b1, e_fetch(1'b1));
        add({n, "_dec"},   o, 6'h00, z, s, 1'b1, e_dec());
        add({n, "_br"},    o, 6'h00, z, s, 1'b1, e_br(pcw));
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic cyc(input string n, input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic s, input logic r, input out_t e);
        sb_t item;
        @(negedge clk);
        rst_n = rst; op = o; func = f; alu_zero = z; alu_sign = s; mem_ready = r;
        item.name = n; item.exp = e;
        sb.push_back(item);
    endtask

    // Compare DUT outputs against the oldest queued expectation, mid low phase.
    always @(negedge clk) begin
        sb_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; op = '0; func = '0; alu_zero = 1'b0; alu_sign = 1'b0; mem_ready = 1'b1;
        #1 rst_n = 1'b0;

        add_r("addu", 6'b100001, 2'd1, 4'd5);
        add_r("sll",  6'b000000, 2'd2, 4'd0);
        add_i("ori",  6'b001101, 1'b1, 4'd8);
        add("lw_fetch", 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add("lw_dec",   6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_dec());
        add("lw_addr",  6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_addr());
        for (int i = 0; i < 3; i++)
            add("lw_rd_wait", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, e_mrd());
        add("lw_rd_ready", 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_mrd());
        add("lw_wb",       6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_lwb());
        add_br("beq_taken",     6'b000100, 1'b1, 1'b0, 1'b1);
        add_br("bne_not_taken", 6'b000101, 1'b1, 1'b0, 1'b0);
        add_br("bne_taken",     6'b000101, 1'b0, 1'b1, 1'b1);
        add_br("blez_neg",      6'b000110, 1'b0, 1'b1, 1'b1);
        add_br("blez_pos",      6'b000110, 1'b0, 1'b0, 1'b0);
        add("sb_fetch", 6'h28, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add("sb_dec",   6'h28, 6'h00, 1'b0, 1'b0, 1'b1, e_dec());
        add("sb_addr",  6'h28, 6'h00, 1'b0, 1'b0, 1'b1, e_addr());
        add("sb_wr",    6'h28, 6'h00, 1'b0, 1'b0, 1'b1, e_mwr(1'b1, 1'b1));
        add("sw_fetch_wait", 6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        add("sw_fetch",      6'h2b, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add("sw_dec",        6'h2b, 6'h00, 1'b0, 1'b0, 1'b1, e_dec());
        add("sw_addr",       6'h2b, 6'h00, 1'b0, 1'b0, 1'b1, e_addr());
        add("sw_wr_wait",    6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, e_mwr(1'b0, 1'b0));
        add("sw_wr",         6'h2b, 6'h00, 1'b0, 1'b0, 1'b1, e_mwr(1'b0, 1'b1));
        add("j_fetch", 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add("j_dec",   6'h02, 6'h00, 1'b0, 1'b0, 1'b1, e_dec());
        add("j_jump",  6'h02, 6'h00, 1'b0, 1'b0, 1'b1, e_jmp());
        add_r("sub",  6'b100010, 2'd1, 4'd6);
        add_r("sra",  6'b000011, 2'd2, 4'd1);
        add_r("srl",  6'b000010, 2'd2, 4'd2);
        add_r("srav", 6'b000111, 2'd1, 4'd1);
        add_r("and",  6'b100100, 2'd1, 4'd7);
        add_r("nor",  6'b100111, 2'd1, 4'd10);
        add_r("slt",  6'b101010, 2'd1, 4'd11);
        add_r("sltu", 6'b101011, 2'd1, 4'd12);
        add_i("addi",  6'b001000, 1'b0, 4'd5);
        add_i("slti",  6'b001010, 1'b0, 4'd11);
        add_i("andi",  6'b001100, 1'b1, 4'd7);
        add_i("xori",  6'b001110, 1'b1, 4'd9);

        cyc("in_reset",      1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, e_idle());
        cyc("reset_wait",    1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, e_idle());
        foreach (rows[i])
            cyc(rows[i].name, 1'b1, rows[i].op, rows[i].func, rows[i].zero, rows[i].sign,
                rows[i].rdy, rows[i].exp);

        // Reset arriving while a load is stalled on memory.
        cyc("lw2_fetch",   1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("lw2_dec",     1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_dec());
        cyc("lw2_addr",    1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, e_addr());
        cyc("lw2_rd_wait", 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, e_mrd());
        cyc("lw2_rst_now", 1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, e_idle());
        cyc("lw2_rst_hold",1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_idle());
        cyc("lw2_restart", 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_idle());
        cyc("add_fetch",   1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("add_dec",     1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_dec());
        cyc("add_exec",    1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_exr(2'd1, 4'd5));
        cyc("add_wb",      1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_rwb());

        // Undecodable opcode parks in trap with no strobes until reset.
        cyc("bad_op_fetch", 1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("bad_op_dec",   1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 1'b1, e_dec());
        for (int i = 0; i < 20; i++)
            cyc("bad_op_trap", 1'b1, 6'h3f, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_trap());
        cyc("trap_rst",     1'b0, 6'h3f, 6'h00, 1'b0, 1'b0, 1'b1, e_idle());
        cyc("trap_release", 1'b1, 6'h00, 6'h26, 1'b0, 1'b0, 1'b1, e_idle());

        // Illegal R-type func (XOR encoding is not supported).
        cyc("bad_fn_fetch", 1'b1, 6'h00, 6'h26, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("bad_fn_dec",   1'b1, 6'h00, 6'h26, 1'b0, 1'b0, 1'b1, e_dec());
        for (int i = 0; i < 3; i++)
            cyc("bad_fn_trap", 1'b1, 6'h00, 6'h26, 1'b0, 1'b0, 1'b1, e_trap());

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
